rv_iommu_regbus_arb: RTL and testbench
======================================

# rv_iommu_regbus_arb

Two-requester register-bus arbiter in front of the IOMMU register map. It shares the single regmap register-bus port between the primary programming path (AXI→APB→reg) and a secondary requester, such as a debug or in-IOMMU configuration agent. Arbitration is round-robin with a registered grant that is held for the whole transaction, and a per-transaction timeout turns a hung access into an error response.

## Interface
- `reg_req_t`, `logic`: register-bus request struct (`addr`, `write`, `wdata`, `wstrb`, `valid`).
- `reg_rsp_t`, `logic`: register-bus response struct (`rdata`, `error`, `ready`).
- `TIMEOUT_CYCLES`, 255: number of BUSY cycles without `ready` before timeout. Legal range 1..65535.
- `CNT_WIDTH`, `$clog2(TIMEOUT_CYCLES+1)`: width of the timeout counter. Derived; do not override.
- `clk_i` input 1: rising-edge clock; the only clock.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `in0_req_i` input `reg_req_t`: requester 0 (programming interface).
- `in0_rsp_o` output `reg_rsp_t`: response to requester 0.
- `in1_req_i` input `reg_req_t`: requester 1 (secondary agent).
- `in1_rsp_o` output `reg_rsp_t`: response to requester 1.
- `regmap_req_o` output `reg_req_t`: request to the register map.
- `regmap_resp_i` input `reg_rsp_t`: response from the register map.

## Operation
- **FSM states:** IDLE, BUSY.
- **Registered state:** `gnt` (1 bit), `prio` (1 bit, the favoured requester), `cnt` (`CNT_WIDTH` bits).
- **Reset values:**
  - State is IDLE; `gnt`=0; `prio`=0; `cnt`=0.
  - All fields of `regmap_req_o`, `in0_rsp_o` and `in1_rsp_o` are 0.
- **IDLE:**
  - `regmap_req_o.valid`=0; both responses are all-zero.
  - If exactly one `inN_req_i.valid` is high: `gnt`←N, go to BUSY.
  - If both are high: `gnt`←`prio`, go to BUSY.
  - `cnt`←0 on entry to BUSY.
- **BUSY, request path:** `regmap_req_o` = `in[gnt]_req_i`, all fields passed through combinationally. `valid` is forced to 1 only while `in[gnt]_req_i.valid`=1.
- **BUSY, response to the non-granted requester:** all-zero; it is stalled.
- **BUSY, completion:** when `regmap_resp_i.ready`=1:
  - `in[gnt]_rsp_o` = `regmap_resp_i` in the same cycle.
  - `prio`←~`gnt`.
  - Next state is IDLE.
- **BUSY, waiting:** when `regmap_resp_i.ready`=0, `cnt`←`cnt`+1.
- **BUSY, timeout:** when `cnt`==`TIMEOUT_CYCLES`-1 and `ready`=0:
  - In that cycle `in[gnt]_rsp_o` = {`ready`=1, `error`=1, `rdata`=0}.
  - `regmap_req_o.valid`=0 in that cycle.
  - `prio`←~`gnt`; next state is IDLE.
  - A late `ready` from the regmap after a timeout is ignored.
- **Protocol violation:** if the granted requester drops `valid` in BUSY before `ready`:
  - Forward `valid`=0 and return to IDLE next cycle.
  - No response is generated and `prio` is unchanged.
- **Response/valid coincidence:** if `ready` and the timeout hit land in the same cycle, `ready` wins: normal response, `error` taken from the regmap.
- **Write strobes and addresses** are passed unmodified; there is no address decode.

## Timing
- Grant is registered: request valid in IDLE at cycle t, `regmap_req_o.valid`=1 at t+1.
- Zero-wait-state regmap: response (`ready`) at t+1. Access latency is 2 cycles from requester valid to `ready`.
- Mandatory IDLE cycle after each completion. Back-to-back throughput is one access per 2 cycles at best.
- With both requesters continuously valid, grants alternate 0,1,0,1… Starvation bound: one transaction of the other requester.
- Timeout response occurs exactly `TIMEOUT_CYCLES` cycles after the first BUSY cycle.
- Reset asserted mid-transaction:
  - All outputs go to 0 immediately (asynchronous).
  - The regmap sees `valid` drop; no response is issued to either requester.
  - After deassertion the block is in IDLE with `prio`=0.

## Test plan
- **Single requester:** in0 write, `addr`=0x20, `wdata`=0xA5A5_0001, `wstrb`=0xF; regmap `ready` in the first BUSY cycle → `regmap_req_o` matches at t+1, `in0_rsp_o.ready`=1 at t+1, `in1_rsp_o` all-zero throughout.
- **Simultaneous after reset:** in0 and in1 both valid reads → in0 is served first (`prio`=0), then in1; `rdata` values 0x1111 and 0x2222 are routed to the correct requester. 4 consecutive contended accesses grant 0,1,0,1.
- **Wait states:** regmap holds `ready`=0 for 5 cycles, then 1 with `rdata`=0xDEAD_BEEF, `error`=0 → in1 receives it on that cycle; `regmap_req_o` is stable through all wait cycles.
- **Timeout:** `TIMEOUT_CYCLES`=8, regmap never ready → `in0_rsp_o` has `ready`=1, `error`=1, `rdata`=0 exactly 8 cycles after BUSY entry; a subsequent in1 request is then granted. A stray regmap `ready` one cycle later produces no response.
- **Ready at the timeout edge:** `ready` arrives in cycle 8 with `TIMEOUT_CYCLES`=8 → normal response with `error`=0.
- **Reset mid-access:** assert `rst_ni`=0 during BUSY with a pending regmap wait → all outputs 0 asynchronously. After release, an in1-only request is granted normally and `prio` is back to 0.

Source files
------------

// File: rtl/rv_iommu_regbus_arb.sv
// Two-requester register-bus arbiter for the IOMMU register map.
// Round-robin grant, registered and held for the whole transaction.
// A hung access is closed with an error response after TIMEOUT_CYCLES.

package rv_iommu_regbus_arb_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

module rv_iommu_regbus_arb #(
    parameter type         reg_req_t      = rv_iommu_regbus_arb_pkg::reg_req_t,
    parameter type         reg_rsp_t      = rv_iommu_regbus_arb_pkg::reg_rsp_t,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned CNT_WIDTH     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t in0_req_i,
    output reg_rsp_t in0_rsp_o,
    input  reg_req_t in1_req_i,
    output reg_rsp_t in1_rsp_o,
    output reg_req_t regmap_req_o,
    input  reg_rsp_t regmap_resp_i
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    // cnt counts BUSY cycles without ready; this value marks the last one
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e               state;
    logic                 gnt;
    logic                 prio;
    logic [CNT_WIDTH-1:0] cnt;

    reg_req_t sel_req;
    reg_rsp_t sel_rsp;
    logic     tmo_hit;

    // Route the granted request to the regmap and its answer back to the owner
    always_comb begin
        regmap_req_o = '0;
        in0_rsp_o    = '0;
        in1_rsp_o    = '0;
        sel_rsp      = '0;
        sel_req      = gnt ? in1_req_i : in0_req_i;
        tmo_hit      = (cnt == TMO_LAST);
        if (state == BUSY) begin
            regmap_req_o = sel_req;
            // A dropped valid is a protocol violation: no response at all
            if (sel_req.valid) begin
                if (regmap_resp_i.ready) begin
                    // ready wins over a coincident timeout
                    sel_rsp = regmap_resp_i;
                end else if (tmo_hit) begin
                    sel_rsp.ready      = 1'b1;
                    sel_rsp.error      = 1'b1;
                    regmap_req_o.valid = 1'b0;
                end
            end
        end
        if (gnt) in1_rsp_o = sel_rsp;
        else     in0_rsp_o = sel_rsp;
    end

    // Arbitration FSM: grant on entry to BUSY, release on completion/timeout/abort
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            gnt   <= 1'b0;
            prio  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in0_req_i.valid || in1_req_i.valid) begin
                        gnt   <= (in0_req_i.valid && in1_req_i.valid) ? prio : in1_req_i.valid;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!sel_req.valid) begin
                        state <= IDLE;
                    end else if (regmap_resp_i.ready || tmo_hit) begin
                        prio  <= ~gnt;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_iommu_regbus_arb.sv
// Bench for rv_iommu_regbus_arb: directed scenarios plus a randomized run,
// all outputs compared every cycle against a transaction-level model.

module tb_rv_iommu_regbus_arb;
    import rv_iommu_regbus_arb_pkg::*;

    localparam int TMO = 8;

    logic     clk, rst_ni, auto_rsp;
    reg_req_t in0_req, in1_req, rm_req;
    reg_rsp_t in0_rsp, in1_rsp, rm_rsp, rsp_drv;

    int tests = 0;
    int fails = 0;

    // model: who owns the bus, how many BUSY cycles have elapsed, whose turn next
    bit       m_busy, m_owner, m_favour;
    int       m_elapsed;
    reg_req_t e_req;
    reg_rsp_t e0, e1;
    reg_req_t s_in0, s_in1;
    reg_rsp_t s_rsp;
    bit       got0, got1;

    rv_iommu_regbus_arb #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .in0_req_i    (in0_req),
        .in0_rsp_o    (in0_rsp),
        .in1_req_i    (in1_req),
        .in1_rsp_o    (in1_rsp),
        .regmap_req_o (rm_req),
        .regmap_resp_i(rm_rsp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // zero-wait regmap answering by address, or a directly driven response
    always_comb begin
        rm_rsp = rsp_drv;
        if (auto_rsp) begin
            rm_rsp.rdata = (rm_req.addr == 32'h4) ? 32'h1111 : 32'h2222;
            rm_rsp.error = 1'b0;
            rm_rsp.ready = 1'b1;
        end
    end

    function automatic reg_req_t mk(logic [31:0] a, logic w, logic [31:0] d, logic [3:0] s);
        reg_req_t r;
        r.addr = a; r.write = w; r.wdata = d; r.wstrb = s; r.valid = 1'b1;
        return r;
    endfunction

    function automatic reg_rsp_t rs(logic [31:0] d, logic e, logic r);
        reg_rsp_t x;
        x.rdata = d; x.error = e; x.ready = r;
        return x;
    endfunction

    function automatic reg_req_t rnd_req();
        return mk($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    endfunction

    function automatic reg_req_t upd(reg_req_t r, bit got);
        if (!r.valid) return ($urandom_range(0, 3) == 0) ? rnd_req() : '0;
        if (got) return ($urandom_range(0, 1) == 1) ? rnd_req() : '0;
        if ($urandom_range(0, 31) == 0) return '0;
        return r;
    endfunction

    // expected outputs this cycle from the transaction view
    function void model_out();
        reg_req_t cur;
        reg_rsp_t ans;
        e_req = '0; e0 = '0; e1 = '0; ans = '0;
        if (m_busy) begin
            cur   = m_owner ? s_in1 : s_in0;
            e_req = cur;
            if (cur.valid) begin
                if (s_rsp.ready) ans = s_rsp;
                else if (m_elapsed == TMO) begin
                    ans         = rs(32'h0, 1'b1, 1'b1);
                    e_req.valid = 1'b0;
                end
            end
            if (m_owner) e1 = ans;
            else         e0 = ans;
        end
    endfunction

    function void model_step();
        reg_req_t cur;
        if (!m_busy) begin
            if (s_in0.valid || s_in1.valid) begin
                m_busy    = 1'b1;
                m_owner   = (s_in0.valid && s_in1.valid) ? m_favour : !s_in0.valid;
                m_elapsed = 1;
            end
        end else begin
            cur = m_owner ? s_in1 : s_in0;
            if (!cur.valid) m_busy = 1'b0;
            else if (s_rsp.ready || m_elapsed == TMO) begin
                m_busy   = 1'b0;
                m_favour = !m_owner;
            end else m_elapsed++;
        end
    endfunction

    task automatic chk_req(input string tag, input reg_req_t obs, input reg_req_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input reg_rsp_t obs, input reg_rsp_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #4;
        s_in0 = in0_req; s_in1 = in1_req; s_rsp = rm_rsp;
        model_out();
        chk_req("model_req", rm_req, e_req);
        chk_rsp("model_rsp0", in0_rsp, e0);
        chk_rsp("model_rsp1", in1_rsp, e1);
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        m_busy = 1'b0; m_favour = 1'b0; m_elapsed = 0;
        chk_req("rst_req", rm_req, '0);
        chk_rsp("rst_rsp0", in0_rsp, '0);
        chk_rsp("rst_rsp1", in1_rsp, '0);
        in0_req = '0; in1_req = '0; rsp_drv = '0; auto_rsp = 1'b0;
        #1;
        rst_ni = 1'b1;
        cyc();
    endtask

    initial begin
        reg_req_t x;
        rst_ni = 1'b1; in0_req = '0; in1_req = '0; rsp_drv = '0; auto_rsp = 1'b0;
        #1;
        do_reset();

        // single requester, zero-wait regmap
        rsp_drv = rs(32'h1234, 1'b0, 1'b1);
        in0_req = mk(32'h20, 1'b1, 32'hA5A5_0001, 4'hF);
        settle();
        chk_rsp("single_idle_rsp0", in0_rsp, '0);
        adv();
        settle();
        chk_req("single_req", rm_req, mk(32'h20, 1'b1, 32'hA5A5_0001, 4'hF));
        chk_rsp("single_rsp0", in0_rsp, rs(32'h1234, 1'b0, 1'b1));
        chk_rsp("single_rsp1", in1_rsp, '0);
        adv();
        in0_req = '0; rsp_drv = '0;
        cyc();

        // contention after reset: grants 0,1,0,1 with data routed back
        do_reset();
        auto_rsp = 1'b1;
        in0_req = mk(32'h4, 1'b0, 32'h0, 4'h0);
        in1_req = mk(32'h8, 1'b0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            settle();
            if (k % 2 == 0) begin
                chk_rsp("rr_rsp0_served", in0_rsp, rs(32'h1111, 1'b0, 1'b1));
                chk_rsp("rr_rsp1_stalled", in1_rsp, '0);
            end else begin
                chk_rsp("rr_rsp1_served", in1_rsp, rs(32'h2222, 1'b0, 1'b1));
                chk_rsp("rr_rsp0_stalled", in0_rsp, '0);
            end
            adv();
        end
        in0_req = '0; in1_req = '0; auto_rsp = 1'b0;
        cyc();

        // wait states on requester 1
        in1_req = mk(32'h30, 1'b0, 32'h0, 4'h0);
        cyc();
        repeat (5) begin
            settle();
            chk_req("wait_req_stable", rm_req, mk(32'h30, 1'b0, 32'h0, 4'h0));
            chk_rsp("wait_rsp1_idle", in1_rsp, '0);
            adv();
        end
        rsp_drv = rs(32'hDEAD_BEEF, 1'b0, 1'b1);
        settle();
        chk_rsp("wait_rsp1_done", in1_rsp, rs(32'hDEAD_BEEF, 1'b0, 1'b1));
        adv();
        in1_req = '0; rsp_drv = '0;
        cyc();

        // timeout on requester 0, stray ready, then requester 1 served
        in0_req = mk(32'h40, 1'b1, 32'h77, 4'h3);
        cyc();
        for (int i = 1; i < TMO; i++) begin
            settle();
            chk_rsp("tmo_pending_rsp0", in0_rsp, '0);
            adv();
        end
        settle();
        chk_rsp("tmo_rsp0", in0_rsp, rs(32'h0, 1'b1, 1'b1));
        x = mk(32'h40, 1'b1, 32'h77, 4'h3);
        x.valid = 1'b0;
        chk_req("tmo_req_novalid", rm_req, x);
        adv();
        in0_req = '0;
        in1_req = mk(32'h50, 1'b0, 32'h0, 4'h0);
        rsp_drv = rs(32'hBAD, 1'b1, 1'b1);
        settle();
        chk_rsp("tmo_stray_rsp0", in0_rsp, '0);
        chk_rsp("tmo_stray_rsp1", in1_rsp, '0);
        adv();
        rsp_drv = '0;
        settle();
        chk_req("tmo_next_gnt1", rm_req, mk(32'h50, 1'b0, 32'h0, 4'h0));
        adv();
        rsp_drv = rs(32'h9, 1'b0, 1'b1);
        cyc();
        in1_req = '0; rsp_drv = '0;
        cyc();

        // ready lands on the timeout cycle
        in0_req = mk(32'h60, 1'b0, 32'h0, 4'h0);
        cyc();
        repeat (TMO - 1) cyc();
        rsp_drv = rs(32'h55, 1'b0, 1'b1);
        settle();
        chk_rsp("edge_rsp0", in0_rsp, rs(32'h55, 1'b0, 1'b1));
        adv();
        in0_req = '0; rsp_drv = '0;
        cyc();

        // reset in the middle of a waiting access (favoured side is 1 here)
        in0_req = mk(32'h70, 1'b1, 32'hCAFE, 4'hF);
        cyc(); cyc(); cyc();
        do_reset();
        auto_rsp = 1'b1;
        in0_req = mk(32'h4, 1'b0, 32'h0, 4'h0);
        in1_req = mk(32'h8, 1'b0, 32'h0, 4'h0);
        cyc();
        settle();
        chk_rsp("postrst_prio0_rsp0", in0_rsp, rs(32'h1111, 1'b0, 1'b1));
        adv();
        in0_req = '0; in1_req = '0; auto_rsp = 1'b0;
        cyc();
        in1_req = mk(32'h80, 1'b1, 32'h5, 4'h1);
        cyc();
        settle();
        chk_req("postrst_gnt1", rm_req, mk(32'h80, 1'b1, 32'h5, 4'h1));
        adv();
        rsp_drv = rs(32'h0, 1'b0, 1'b1);
        cyc();
        in1_req = '0; rsp_drv = '0;
        cyc();

        // randomized traffic, faster then slower regmap
        for (int i = 0; i < 600; i++) begin
            rsp_drv = rs($urandom, 1'($urandom_range(0, 1)),
                         ($urandom_range(0, (i < 300) ? 2 : 11) == 0));
            settle();
            got0 = e0.ready; got1 = e1.ready;
            adv();
            in0_req = upd(in0_req, got0);
            in1_req = upd(in1_req, got1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
